// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised line, fixed PRESCALE oversampling, single mid-bit sample,
// optional even/odd parity; Data_valid/Par_err/Stp_err strobe one cycle after the stop sample.
module uart_rx #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             RX_in,
    input  logic             Par_en,
    input  logic             Par_type,
    output logic [WIDTH-1:0] P_data,
    output logic             Data_valid,
    output logic             Par_err,
    output logic             Stp_err,
    output logic             Busy
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int BW = $clog2(WIDTH) + 1;

    localparam logic [CW-1:0] HALF_CNT = CW'(PRESCALE / 2);
    localparam logic [CW-1:0] LAST_CNT = CW'(PRESCALE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       sync_q;
    logic             rx_s;
    logic [CW-1:0]    cnt;
    logic [BW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shreg;
    logic             par_en_q;
    logic             par_type_q;
    logic             par_bad;
    logic             smp;
    logic             frame_done;

    // Line is idle-high, so the synchroniser resets to 1 to avoid a false start
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], RX_in};
        end
    end

    assign rx_s = sync_q[1];
    assign smp  = (cnt == HALF_CNT);
    assign Busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (smp) begin
                    state_nxt = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (smp && (bit_cnt == LAST_BIT)) begin
                    state_nxt = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (smp) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (smp) begin
                    state_nxt  = IDLE;
                    frame_done = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Bit timing: cnt wraps every PRESCALE cycles from START entry, sampling at mid-bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_en_q   <= 1'b0;
            par_type_q <= 1'b0;
            par_bad    <= 1'b0;
        end else begin
            if (state == IDLE) begin
                cnt     <= '0;
                bit_cnt <= '0;
                par_bad <= 1'b0;
                if (!rx_s) begin
                    par_en_q   <= Par_en;
                    par_type_q <= Par_type;
                end
            end else begin
                cnt <= (cnt == LAST_CNT) ? '0 : cnt + 1'b1;
            end

            if ((state == DATA) && smp) begin
                shreg   <= {rx_s, shreg[WIDTH-1:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end

            if ((state == PARITY) && smp) begin
                par_bad <= (rx_s != ((^shreg) ^ par_type_q));
            end
        end
    end

    // Result strobes land on the first IDLE cycle after the stop sample
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            P_data     <= '0;
            Data_valid <= 1'b0;
            Par_err    <= 1'b0;
            Stp_err    <= 1'b0;
        end else begin
            Data_valid <= 1'b0;
            Par_err    <= 1'b0;
            Stp_err    <= 1'b0;
            if (frame_done) begin
                if (rx_s && !par_bad) begin
                    P_data     <= shreg;
                    Data_valid <= 1'b1;
                end else begin
                    Stp_err <= !rx_s;
                    Par_err <= par_bad;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a serial TX model drives frames, a monitor logs every strobe,
// and each test compares the logged strobes against its own expected queue.
module tb_uart_rx;

    localparam int W     = 8;
    localparam int P     = 8;
    localparam int HALF  = P / 2;
    localparam int LAT_P = HALF + P * (W + 2) + 1;
    localparam int LAT_N = HALF + P * (W + 1) + 1;

    logic         clk      = 1'b0;
    logic         rst      = 1'b0;
    logic         RX_in    = 1'b1;
    logic         Par_en   = 1'b0;
    logic         Par_type = 1'b0;
    logic [W-1:0] P_data;
    logic         Data_valid;
    logic         Par_err;
    logic         Stp_err;
    logic         Busy;

    always #5 clk = ~clk;

    uart_rx #(.WIDTH(W), .PRESCALE(P)) dut (
        .clk        (clk),
        .rst        (rst),
        .RX_in      (RX_in),
        .Par_en     (Par_en),
        .Par_type   (Par_type),
        .P_data     (P_data),
        .Data_valid (Data_valid),
        .Par_err    (Par_err),
        .Stp_err    (Stp_err),
        .Busy       (Busy)
    );

    typedef struct {
        logic [W-1:0] d;
        logic         dv;
        logic         pe;
        logic         se;
        int           lat;
    } ev_t;

    ev_t          exp_q[$];
    ev_t          obs_q[$];
    int           errors    = 0;
    int           checks    = 0;
    int           cyc       = 0;
    int           rise_cyc  = 0;
    int           rise_cnt  = 0;
    int           cur_len   = 0;
    int           last_len  = 0;
    logic         busy_q    = 1'b0;
    logic [W-1:0] last_good = '0;

    // Latency is measured from the first cycle Busy is seen high
    always @(negedge clk) begin
        ev_t o;
        cyc++;
        if (Busy && !busy_q) begin
            rise_cyc = cyc;
            rise_cnt++;
            cur_len = 0;
        end
        if (Busy) cur_len++;
        else if (busy_q) last_len = cur_len;
        busy_q = Busy;
        if (Data_valid || Par_err || Stp_err) begin
            o.d   = P_data;
            o.dv  = Data_valid;
            o.pe  = Par_err;
            o.se  = Stp_err;
            o.lat = cyc - rise_cyc;
            obs_q.push_back(o);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic v);
        RX_in = v;
        tick(P);
    endtask

    task automatic send_frame(input logic [W-1:0] d, input logic pen, input logic pbit,
                              input logic stop, input int stop_len, input logic disturb);
        send_bit(1'b0);
        for (int i = 0; i < W; i++) begin
            if (disturb && i == 3) begin
                Par_en   = ~Par_en;
                Par_type = ~Par_type;
            end
            send_bit(d[i]);
        end
        if (pen) send_bit(pbit);
        RX_in = stop;
        tick(stop_len);
        RX_in = 1'b1;
        if (disturb) begin
            Par_en   = ~Par_en;
            Par_type = ~Par_type;
        end
    endtask

    function automatic ev_t mk(input logic [W-1:0] d, input logic dv, input logic pe,
                               input logic se, input int lat);
        ev_t e;
        e.d = d; e.dv = dv; e.pe = pe; e.se = se; e.lat = lat;
        return e;
    endfunction

    task automatic test_reset();
        ev_t e, o;
        checks++;
        if ({P_data, Data_valid, Par_err, Stp_err, Busy} !== 12'h0) begin
            errors++;
            $display("FAIL reset_state: got %h, expected 000", {P_data, Data_valid, Par_err, Stp_err, Busy});
        end
        rst = 1'b1;
        tick(4);
        exp_q.push_back(mk(8'h5A, 1'b1, 1'b0, 1'b0, LAT_N));
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, P, 1'b0);
        tick(P);
        // abort 0x3C after three data bits
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
        tick(3);
        rst = 1'b0;
        #1;
        checks++;
        if ({P_data, Data_valid, Par_err, Stp_err, Busy} !== 12'h0) begin
            errors++;
            $display("FAIL reset_abort: got %h, expected 000", {P_data, Data_valid, Par_err, Stp_err, Busy});
        end
        RX_in = 1'b1;
        tick(4);
        rst = 1'b1;
        tick(12 * P);
        exp_q.push_back(mk(8'h3C, 1'b1, 1'b0, 1'b0, LAT_N));
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, P, 1'b0);
        for (int i = 0; i < 600 && obs_q.size() < exp_q.size(); i++) tick(1);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL reset_count: got %0d strobes, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks += 3;
            if (o.d !== e.d) begin errors++; $display("FAIL reset_data: got %h, expected %h", o.d, e.d); end
            if ({o.dv, o.pe, o.se} !== {e.dv, e.pe, e.se}) begin errors++; $display("FAIL reset_flags: got %b, expected %b", {o.dv, o.pe, o.se}, {e.dv, e.pe, e.se}); end
            if (o.lat !== e.lat) begin errors++; $display("FAIL reset_latency: got %0d, expected %0d", o.lat, e.lat); end
        end
        exp_q.delete(); obs_q.delete();
        last_good = 8'h3C;
    endtask

    task automatic test_parity();
        ev_t e, o;
        Par_en = 1'b1; Par_type = 1'b0;
        exp_q.push_back(mk(8'hA5, 1'b1, 1'b0, 1'b0, LAT_P));
        send_frame(8'hA5, 1'b1, ^8'hA5, 1'b1, P, 1'b1);
        tick(2 * P);
        last_good = 8'hA5;
        Par_type = 1'b1;
        exp_q.push_back(mk(last_good, 1'b0, 1'b1, 1'b0, LAT_P));
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1, P, 1'b0);
        tick(2 * P);
        exp_q.push_back(mk(last_good, 1'b0, 1'b1, 1'b0, LAT_P));
        send_frame(8'h3F, 1'b1, 1'b0, 1'b1, P, 1'b0);
        tick(2 * P);
        exp_q.push_back(mk(last_good, 1'b0, 1'b1, 1'b1, LAT_P));
        send_frame(8'h3F, 1'b1, 1'b0, 1'b0, P, 1'b0);
        tick(2 * P);
        for (int i = 0; i < 600 && obs_q.size() < exp_q.size(); i++) tick(1);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL parity_count: got %0d strobes, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks += 3;
            if (o.d !== e.d) begin errors++; $display("FAIL parity_data: got %h, expected %h", o.d, e.d); end
            if ({o.dv, o.pe, o.se} !== {e.dv, e.pe, e.se}) begin errors++; $display("FAIL parity_flags: got %b, expected %b", {o.dv, o.pe, o.se}, {e.dv, e.pe, e.se}); end
            if (o.lat !== e.lat) begin errors++; $display("FAIL parity_latency: got %0d, expected %0d", o.lat, e.lat); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_framing();
        ev_t e, o;
        Par_en = 1'b0; Par_type = 1'b0;
        exp_q.push_back(mk(last_good, 1'b0, 1'b0, 1'b1, LAT_N));
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, P, 1'b0);
        tick(2 * P);
        exp_q.push_back(mk(8'h81, 1'b1, 1'b0, 1'b0, LAT_N));
        send_frame(8'h81, 1'b0, 1'b0, 1'b1, P, 1'b0);
        for (int i = 0; i < 600 && obs_q.size() < exp_q.size(); i++) tick(1);
        tick(P);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL framing_count: got %0d strobes, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks += 3;
            if (o.d !== e.d) begin errors++; $display("FAIL framing_data: got %h, expected %h", o.d, e.d); end
            if ({o.dv, o.pe, o.se} !== {e.dv, e.pe, e.se}) begin errors++; $display("FAIL framing_flags: got %b, expected %b", {o.dv, o.pe, o.se}, {e.dv, e.pe, e.se}); end
            if (o.lat !== e.lat) begin errors++; $display("FAIL framing_latency: got %0d, expected %0d", o.lat, e.lat); end
        end
        exp_q.delete(); obs_q.delete();
        last_good = 8'h81;
    endtask

    task automatic test_glitch();
        int rise0;
        rise0 = rise_cnt;
        RX_in = 1'b0;
        tick(2);
        RX_in = 1'b1;
        tick(3 * P);
        checks += 4;
        if (rise_cnt !== rise0 + 1) begin errors++; $display("FAIL glitch_busy_pulse: got %0d pulses, expected 1", rise_cnt - rise0); end
        if (last_len !== HALF + 1) begin errors++; $display("FAIL glitch_busy_len: got %0d, expected %0d", last_len, HALF + 1); end
        if (Busy !== 1'b0) begin errors++; $display("FAIL glitch_idle: got Busy=%b, expected 0", Busy); end
        if (obs_q.size() != 0) begin errors++; $display("FAIL glitch_strobes: got %0d, expected 0", obs_q.size()); end
        obs_q.delete();
        checks++;
        if (P_data !== last_good) begin errors++; $display("FAIL glitch_pdata: got %h, expected %h", P_data, last_good); end
    endtask

    task automatic test_back_to_back();
        ev_t e, o;
        logic [W-1:0] words [3];
        words[0] = 8'h00; words[1] = 8'hFF; words[2] = 8'h55;
        Par_en = 1'b1; Par_type = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(mk(words[k], 1'b1, 1'b0, 1'b0, LAT_P));
            send_frame(words[k], 1'b1, ~(^words[k]), 1'b1, P, 1'b0);
        end
        Par_en = 1'b0; Par_type = 1'b0;
        // shortest stop bit the receiver must still accept before the next start edge
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(mk(words[k], 1'b1, 1'b0, 1'b0, LAT_N));
            send_frame(words[k], 1'b0, 1'b0, 1'b1, HALF + 2, 1'b0);
        end
        for (int i = 0; i < 600 && obs_q.size() < exp_q.size(); i++) tick(1);
        tick(P);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL b2b_count: got %0d strobes, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks += 3;
            if (o.d !== e.d) begin errors++; $display("FAIL b2b_data: got %h, expected %h", o.d, e.d); end
            if ({o.dv, o.pe, o.se} !== {e.dv, e.pe, e.se}) begin errors++; $display("FAIL b2b_flags: got %b, expected %b", {o.dv, o.pe, o.se}, {e.dv, e.pe, e.se}); end
            if (o.lat !== e.lat) begin errors++; $display("FAIL b2b_latency: got %0d, expected %0d", o.lat, e.lat); end
        end
        exp_q.delete(); obs_q.delete();
        last_good = 8'h55;
        checks++;
        if (P_data !== last_good) begin errors++; $display("FAIL b2b_pdata_hold: got %h, expected %h", P_data, last_good); end
    endtask

    initial begin
        tick(3);
        test_reset();
        test_parity();
        test_framing();
        test_glitch();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
